// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imm_pkg
// Purpose  : Shared definitions for the immediate-extension pipeline.
//            Holds the ImmSrc mode encodings and the default output width.
// Revision : 1.0 - initial release
// ============================================================================
package imm_pkg;

    // Default width of the extended immediate
    localparam int XLEN_DEFAULT = 32;

    // ImmSrc extension modes
    typedef enum logic [1:0] {
        IMM_DP8   = 2'b00,  // 8-bit data-processing immediate, zero-extended
        IMM_MEM12 = 2'b01,  // 12-bit memory offset, zero-extended
        IMM_BR24  = 2'b10,  // 24-bit branch offset, word-scaled, sign-extended
        IMM_ROT   = 2'b11   // ARM rotated immediate (optional)
    } imm_src_e;

endpackage : imm_pkg
`default_nettype wire

// File: rtl/imm_extend_core.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_core
// Purpose  : Combinational immediate extender.
//            Mode 11 (rotated immediate) is built only when IMM_EXTEND_ROT_EN
//            is defined; otherwise it yields zero and flags err. The rotated
//            form needs XLEN >= 32.
// Ports    : Instr  [23:0]   instruction immediate field
//            ImmSrc [1:0]    extension mode
//            ExtImm [XLEN-1] extended immediate
//            err             unsupported mode requested
// Revision : 1.0 - initial release
// ============================================================================
module imm_extend_core
    import imm_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [23:0]     Instr,
    input  logic [1:0]      ImmSrc,
    output logic [XLEN-1:0] ExtImm,
    output logic            err
);

`ifdef IMM_EXTEND_ROT_EN
    logic [31:0] w_rot_base;
    logic [4:0]  w_rot_amt;
    logic [31:0] w_rot32;

    // Rotate right by twice the 4-bit rotate field; a rotate of 0 makes the
    // left-shift term shift by 32, which correctly contributes nothing.
    always_comb begin
        w_rot_base = {24'd0, Instr[7:0]};
        w_rot_amt  = {Instr[11:8], 1'b0};
        w_rot32    = (w_rot_base >> w_rot_amt) |
                     (w_rot_base << (6'd32 - {1'b0, w_rot_amt}));
    end
`endif

    always_comb begin
        ExtImm = '0;
        err    = 1'b0;
        case (ImmSrc)
            IMM_DP8:   ExtImm[7:0]  = Instr[7:0];
            IMM_MEM12: ExtImm[11:0] = Instr[11:0];
            IMM_BR24: begin
                // Fill with the sign, then overlay the 26-bit scaled offset;
                // at XLEN = 26 the fill is entirely overwritten.
                ExtImm       = {XLEN{Instr[23]}};
                ExtImm[25:0] = {Instr, 2'b00};
            end
            IMM_ROT: begin
`ifdef IMM_EXTEND_ROT_EN
                ExtImm[31:0] = w_rot32;
`else
                err = 1'b1;
`endif
            end
        endcase
    end

endmodule : imm_extend_core
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_pipe
// Purpose  : Two-stage valid/ready pipeline around imm_extend_core.
//            S1 captures the request, S2 holds the extended result.
//            Optional feature macro: IMM_EXTEND_ROT_EN (mode 11 rotation).
// Ports    : clk, reset_n (async active-low), flush (sync)
//            in_valid/in_ready, Instr[23:0], ImmSrc[1:0], in_tag[TAG_W-1:0]
//            out_valid/out_ready, ExtImm[XLEN-1:0], out_tag, out_err
// Revision : 1.0 - initial release
// ============================================================================
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      Instr,
    input  logic [1:0]       ImmSrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  ExtImm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    // Stage 1: captured request
    logic             r_s1_valid;
    logic [23:0]      r_s1_instr;
    logic [1:0]       r_s1_src;
    logic [TAG_W-1:0] r_s1_tag;

    // Stage 2: computed result
    logic             r_s2_valid;
    logic [XLEN-1:0]  r_s2_imm;
    logic [TAG_W-1:0] r_s2_tag;
    logic             r_s2_err;

    logic             w_s1_adv;
    logic             w_in_fire;
    logic [XLEN-1:0]  w_imm;
    logic             w_err;

    imm_extend_core #(
        .XLEN   (XLEN)
    ) u_core (
        .Instr  (r_s1_instr),
        .ImmSrc (r_s1_src),
        .ExtImm (w_imm),
        .err    (w_err)
    );

    // S1 moves into S2 whenever S2 is empty or is being drained this cycle.
    // reset_n gates in_ready so nothing is offered while reset is held.
    always_comb begin
        w_s1_adv  = r_s1_valid && (!r_s2_valid || out_ready);
        in_ready  = reset_n && !flush && (!r_s1_valid || w_s1_adv);
        w_in_fire = in_valid && in_ready;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_instr <= '0;
            r_s1_src   <= '0;
            r_s1_tag   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_imm   <= '0;
            r_s2_tag   <= '0;
            r_s2_err   <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s2_valid <= 1'b1;
                r_s2_imm   <= w_imm;
                r_s2_tag   <= r_s1_tag;
                r_s2_err   <= w_err;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end

            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_instr <= Instr;
                r_s1_src   <= ImmSrc;
                r_s1_tag   <= in_tag;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Result registers only change on an S2 load, so they hold under stall
    assign out_valid = r_s2_valid;
    assign ExtImm    = r_s2_imm;
    assign out_tag   = r_s2_tag;
    assign out_err   = r_s2_err;

endmodule : imm_extend_pipe
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_extend_pipe
// Purpose  : Directed self-checking bench for imm_extend_pipe (XLEN 32 and a
//            second XLEN 64 instance sharing the same stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready64;
    logic [23:0] Instr;
    logic [1:0]  ImmSrc;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_valid64;
    logic        out_ready;
    logic [31:0] ExtImm;
    logic [63:0] ExtImm64;
    logic [3:0]  out_tag;
    logic [3:0]  out_tag64;
    logic        out_err;
    logic        out_err64;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(32), .TAG_W(4)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Instr     (Instr),
        .ImmSrc    (ImmSrc),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ExtImm    (ExtImm),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    imm_extend_pipe #(.XLEN(64), .TAG_W(4)) u_dut64 (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready64),
        .Instr     (Instr),
        .ImmSrc    (ImmSrc),
        .in_tag    (in_tag),
        .out_valid (out_valid64),
        .out_ready (out_ready),
        .ExtImm    (ExtImm64),
        .out_tag   (out_tag64),
        .out_err   (out_err64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] src, input logic [23:0] ins,
                         input logic [3:0] tg);
        in_valid = v;
        ImmSrc   = src;
        Instr    = ins;
        in_tag   = tg;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] imm,
                             input logic [3:0] tg, input logic er);
        check({tag, "_valid"}, 64'(out_valid), 64'(v));
        check({tag, "_imm"},   64'(ExtImm),    64'(imm));
        check({tag, "_tag"},   64'(out_tag),   64'(tg));
        check({tag, "_err"},   64'(out_err),   64'(er));
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 2'b00, 24'h0, 4'h0);

        // ---------------- reset state ----------------
        #2;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check_out("rst", 1'b0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'd1);

        // ---------------- streaming ----------------
        @(negedge clk);
        drive(1'b1, 2'b00, 24'h0000AB, 4'h1);
        @(negedge clk);
        check("str_lat", 64'(out_valid), 64'd0);
        drive(1'b1, 2'b01, 24'h000FFF, 4'h2);
        @(negedge clk);
        check_out("str0", 1'b1, 32'h000000AB, 4'h1, 1'b0);
        drive(1'b1, 2'b10, 24'h800001, 4'h3);
        @(negedge clk);
        check_out("str1", 1'b1, 32'h00000FFF, 4'h2, 1'b0);
        drive(1'b0, 2'b00, 24'h0, 4'h0);
        @(negedge clk);
        check_out("str2", 1'b1, 32'hFE000004, 4'h3, 1'b0);
        check("str2_x64", ExtImm64, 64'hFFFFFFFF_FE000004);
        @(negedge clk);
        check("str_empty", 64'(out_valid), 64'd0);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 24'h000123, 4'h3);
        #1;
        check("bp_rdy0", 64'(in_ready), 64'd1);
        @(negedge clk);
        drive(1'b1, 2'b00, 24'h0000CD, 4'h4);
        #1;
        check("bp_rdy1", 64'(in_ready), 64'd1);
        @(negedge clk);
        drive(1'b1, 2'b10, 24'hFFFFFF, 4'h5);
        #1;
        check("bp_rdy_drop", 64'(in_ready), 64'd0);
        check_out("bp_hold0", 1'b1, 32'h00000123, 4'h3, 1'b0);
        @(negedge clk);
        check_out("bp_hold1", 1'b1, 32'h00000123, 4'h3, 1'b0);
        @(negedge clk);
        check_out("bp_hold2", 1'b1, 32'h00000123, 4'h3, 1'b0);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp_rdy_back", 64'(in_ready), 64'd1);
        check_out("bp_r0", 1'b1, 32'h00000123, 4'h3, 1'b0);
        @(negedge clk);
        drive(1'b0, 2'b00, 24'h0, 4'h0);
        check_out("bp_r1", 1'b1, 32'h000000CD, 4'h4, 1'b0);
        @(negedge clk);
        check_out("bp_r2", 1'b1, 32'hFFFFFFFC, 4'h5, 1'b0);
        check("bp_r2_x64", ExtImm64, 64'hFFFFFFFF_FFFFFFFC);
        @(negedge clk);
        check("bp_empty", 64'(out_valid), 64'd0);

        // ---------------- mode 11 ----------------
        drive(1'b1, 2'b11, 24'h0004FF, 4'h6);
        @(negedge clk);
        drive(1'b0, 2'b00, 24'h0, 4'h0);
        @(negedge clk);
`ifdef IMM_EXTEND_ROT_EN
        check_out("rot", 1'b1, 32'hFF000000, 4'h6, 1'b0);
`else
        check_out("rot", 1'b1, 32'h00000000, 4'h6, 1'b1);
`endif
        @(negedge clk);

        // ---------------- flush ----------------
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 24'h000011, 4'h7);
        @(negedge clk);
        drive(1'b1, 2'b00, 24'h000022, 4'h8);
        @(negedge clk);
        check("fl_full", 64'(out_valid), 64'd1);
        drive(1'b1, 2'b00, 24'h000033, 4'h9);
        flush = 1'b1;
        #1;
        check("fl_rdy", 64'(in_ready), 64'd0);
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 2'b00, 24'h0, 4'h0);
        check("fl_out0", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("fl_out1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("fl_out2", 64'(out_valid), 64'd0);

        // ---------------- reset mid-stream ----------------
        drive(1'b1, 2'b00, 24'h0000AA, 4'hA);
        @(negedge clk);
        drive(1'b1, 2'b01, 24'h000BBB, 4'hB);
        @(negedge clk);
        drive(1'b0, 2'b00, 24'h0, 4'h0);
        check("mr_pre", 64'(out_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mr_rdy", 64'(in_ready), 64'd0);
        check_out("mr", 1'b0, 32'h0, 4'h0, 1'b0);
        check("mr_x64", ExtImm64, 64'h0);
        reset_n = 1'b1;
        @(negedge clk);
        check("mr_post0", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("mr_post1", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_imm_extend_pipe
`default_nettype wire
